instr_mem_prog: RTL and testbench

- Parametrised, byte-addressed, big-endian instruction memory for the MIPS datapath. It supersedes the fixed 16-bit, 256-byte combinational ROM.
- Adds a registered fetch port with valid/ready handshake and fault reporting for misaligned and out-of-range addresses.
- Adds a load mode. A boot/debug loader streams program bytes in through an auto-incrementing write pointer.
- Sits between the PC/IF stage and the IF/ID pipeline register.

---
 rtl/instr_mem_prog.sv | 145 ++++++++++++++
 tb/tb_instr_mem_prog.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_prog.sv
// Byte-addressed, big-endian instruction memory with a registered fetch port
// and a streaming byte loader (RUN / LOAD / DRAIN).
module instr_mem_prog #(
    parameter int INSTR_W     = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           prog_en,
    input  logic                           prog_we,
    input  logic [7:0]                     prog_data,
    output logic [$clog2(DEPTH_BYTES)-1:0] prog_ptr,
    output logic                           prog_ovf,
    input  logic                           fetch_req,
    input  logic [ADDR_W-1:0]              fetch_addr,
    output logic                           fetch_rdy,
    output logic                           instr_valid,
    output logic [INSTR_W-1:0]             instruction,
    output logic                           fetch_err
);

    localparam int BPI = INSTR_W / 8;
    localparam int PW  = $clog2(DEPTH_BYTES);
    // Range check is done at least 32 bits wide so large addresses never alias.
    localparam int XW  = (ADDR_W > 32) ? ADDR_W : 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        mem_r [DEPTH_BYTES];
    logic              load_entry_s;
    logic              wr_en_s;
    logic              accept_s;
    logic              misalign_s;
    logic              oor_s;
    logic [XW-1:0]     addr_ext_s;
    logic [PW-1:0]     addr_idx_s;
    logic [INSTR_W-1:0] rd_word_s;

    assign fetch_rdy    = (state_r == ST_RUN) && !prog_en;
    assign load_entry_s = (state_r == ST_RUN) && prog_en;
    assign wr_en_s      = (state_r == ST_LOAD) && prog_we;
    assign accept_s     = fetch_req && fetch_rdy;
    assign addr_ext_s   = XW'(fetch_addr);
    assign addr_idx_s   = fetch_addr[PW-1:0];
    assign misalign_s   = (fetch_addr % ADDR_W'(BPI)) != {ADDR_W{1'b0}};
    assign oor_s        = addr_ext_s > XW'(DEPTH_BYTES - BPI);

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Mode next-state logic; DRAIN gives the last loaded byte a cycle to settle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (prog_en) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (prog_en) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_RUN;
        endcase
    end

    // Load pointer and sticky wrap flag, both cleared on every LOAD entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_ptr <= {PW{1'b0}};
            prog_ovf <= 1'b0;
        end else if (load_entry_s) begin
            prog_ptr <= {PW{1'b0}};
            prog_ovf <= 1'b0;
        end else if (wr_en_s) begin
            prog_ptr <= prog_ptr + PW'(1);
            if (prog_ptr == PW'(DEPTH_BYTES - 1)) begin
                prog_ovf <= 1'b1;
            end else begin
                prog_ovf <= prog_ovf;
            end
        end else begin
            prog_ptr <= prog_ptr;
            prog_ovf <= prog_ovf;
        end
    end

    // Byte array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[prog_ptr] <= prog_data;
        end
    end

    // Big-endian gather: the byte at the fetch address lands in the MSB.
    always_comb begin
        rd_word_s = {INSTR_W{1'b0}};
        for (int b = 0; b < BPI; b++) begin
            rd_word_s[INSTR_W-1-8*b -: 8] = mem_r[addr_idx_s + PW'(b)];
        end
    end

    // Registered fetch response; faults return a NOP and skip the array read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            instruction <= {INSTR_W{1'b0}};
        end else if (accept_s) begin
            instr_valid <= 1'b1;
            if (misalign_s || oor_s) begin
                fetch_err   <= 1'b1;
                instruction <= {INSTR_W{1'b0}};
            end else begin
                fetch_err   <= 1'b0;
                instruction <= rd_word_s;
            end
        end else begin
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            instruction <= instruction;
        end
    end

endmodule

// File: tb/tb_instr_mem_prog.sv
// Scoreboard bench for instr_mem_prog: a 16-bit/256-byte instance and a
// 32-bit/1024-byte instance, each with its own expected-response queue.
module tb_instr_mem_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        pe, pw;
    logic [7:0]  pd;
    logic [7:0]  pptr;
    logic        povf, freq, frdy, ival, ferr;
    logic [15:0] faddr, instr;

    logic        pe2, pw2;
    logic [7:0]  pd2;
    logic [9:0]  pptr2;
    logic        povf2, freq2, frdy2, ival2, ferr2;
    logic [15:0] faddr2;
    logic [31:0] instr2;

    instr_mem_prog #(.INSTR_W(16), .ADDR_W(16), .DEPTH_BYTES(256)) u16 (
        .clk(clk), .rst_n(rst_n), .prog_en(pe), .prog_we(pw), .prog_data(pd),
        .prog_ptr(pptr), .prog_ovf(povf), .fetch_req(freq), .fetch_addr(faddr),
        .fetch_rdy(frdy), .instr_valid(ival), .instruction(instr), .fetch_err(ferr)
    );

    instr_mem_prog #(.INSTR_W(32), .ADDR_W(16), .DEPTH_BYTES(1024)) u32 (
        .clk(clk), .rst_n(rst_n), .prog_en(pe2), .prog_we(pw2), .prog_data(pd2),
        .prog_ptr(pptr2), .prog_ovf(povf2), .fetch_req(freq2), .fetch_addr(faddr2),
        .fetch_rdy(frdy2), .instr_valid(ival2), .instruction(instr2), .fetch_err(ferr2)
    );

    typedef struct packed {
        logic        err;
        logic        dc;
        logic [31:0] word;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prog(input int which, input logic en, input logic we, input logic [7:0] d);
        if (which == 0) begin
            pe = en; pw = we; pd = d;
        end else begin
            pe2 = en; pw2 = we; pd2 = d;
        end
    endtask

    // Drives one fetch request and queues its expected response; caller ticks.
    task automatic issue(input int which, input logic [15:0] a, input logic err,
                         input logic dc, input logic [31:0] w);
        exp_t e;
        e.err = err; e.dc = dc; e.word = w;
        if (which == 0) begin
            freq = 1'b1; faddr = a; #1;
            check("fetch_rdy16", 32'(frdy), 32'd1);
            q16.push_back(e);
        end else begin
            freq2 = 1'b1; faddr2 = a; #1;
            check("fetch_rdy32", 32'(frdy2), 32'd1);
            q32.push_back(e);
        end
    endtask

    task automatic idle_fetch();
        freq = 1'b0; freq2 = 1'b0;
    endtask

    task automatic wait_rdy(input int which);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if ((which == 0 && frdy) || (which != 0 && frdy2)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wait_rdy_timeout", 32'(ok), 32'd1);
    endtask

    // Enter LOAD, stream the bytes, drop prog_en, and return once back in RUN.
    task automatic load_bytes(input int which, input logic [7:0] b [$]);
        set_prog(which, 1'b1, 1'b0, 8'h00);
        tick();
        foreach (b[i]) begin
            set_prog(which, 1'b1, 1'b1, b[i]);
            tick();
        end
        set_prog(which, 1'b0, 1'b0, 8'h00);
        wait_rdy(which);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && ival === 1'b1) begin
            if (q16.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_valid16: got valid=1 expected no response");
            end else begin
                e = q16.pop_front();
                check("fetch_err16", 32'(ferr), 32'(e.err));
                if (!e.dc) check("instruction16", 32'(instr), e.word);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && ival2 === 1'b1) begin
            if (q32.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_valid32: got valid=1 expected no response");
            end else begin
                e = q32.pop_front();
                check("fetch_err32", 32'(ferr2), 32'(e.err));
                if (!e.dc) check("instruction32", instr2, e.word);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq [$];
        rst_n = 1'b0;
        set_prog(0, 1'b0, 1'b0, 8'h00);
        set_prog(1, 1'b0, 1'b0, 8'h00);
        freq = 1'b0; faddr = 16'h0000; freq2 = 1'b0; faddr2 = 16'h0000;
        tick(); tick();
        check("rst_ptr", 32'(pptr), 32'd0);
        check("rst_ovf", 32'(povf), 32'd0);
        check("rst_valid", 32'(ival), 32'd0);
        check("rst_err", 32'(ferr), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_rdy", 32'(frdy), 32'd1);

        // Test 1: four-byte load, back-to-back aligned fetches
        set_prog(0, 1'b1, 1'b0, 8'h00);
        tick();
        bq = '{8'hE1, 8'h88, 8'h0C, 8'h70};
        foreach (bq[i]) begin
            set_prog(0, 1'b1, 1'b1, bq[i]);
            tick();
        end
        set_prog(0, 1'b0, 1'b0, 8'h00);
        check("load_ptr4", 32'(pptr), 32'd4);
        wait_rdy(0);
        issue(0, 16'h0000, 1'b0, 1'b0, 32'h0000_E188);
        tick();
        issue(0, 16'h0002, 1'b0, 1'b0, 32'h0000_0C70);
        tick();
        idle_fetch();
        tick();

        // Test 4 + 3: fetch collides with prog_en rising, then 257-byte load
        pe = 1'b1; freq = 1'b1; faddr = 16'h0000; #1;
        check("rdy_on_prog_en", 32'(frdy), 32'd0);
        tick();
        freq = 1'b0;
        check("rdy_in_load", 32'(frdy), 32'd0);
        check("entry_ptr", 32'(pptr), 32'd0);
        for (int i = 0; i < 257; i++) begin
            set_prog(0, 1'b1, 1'b1, (i < 256) ? (8'(i) ^ 8'h5A) : 8'h3C);
            tick();
            if (i == 254) begin
                check("ovf_before_wrap", 32'(povf), 32'd0);
                check("ptr_255", 32'(pptr), 32'd255);
            end
            if (i == 255) begin
                check("ovf_at_wrap", 32'(povf), 32'd1);
                check("ptr_wrap0", 32'(pptr), 32'd0);
            end
        end
        check("ptr_after_257", 32'(pptr), 32'd1);
        set_prog(0, 1'b0, 1'b0, 8'h00);
        #1;
        check("rdy_load_en_low", 32'(frdy), 32'd0);
        tick();
        check("rdy_in_drain", 32'(frdy), 32'd0);
        tick();
        check("rdy_after_drain", 32'(frdy), 32'd1);
        check("ovf_sticky_run", 32'(povf), 32'd1);
        set_prog(0, 1'b1, 1'b0, 8'h00);
        tick();
        check("reentry_ovf", 32'(povf), 32'd0);
        check("reentry_ptr", 32'(pptr), 32'd0);
        set_prog(0, 1'b0, 1'b0, 8'h00);
        wait_rdy(0);

        // Test 2: faults and boundary address
        issue(0, 16'h0003, 1'b1, 1'b0, 32'h0);
        tick();
        issue(0, 16'h0100, 1'b1, 1'b0, 32'h0);
        tick();
        issue(0, 16'h8000, 1'b1, 1'b0, 32'h0);
        tick();
        issue(0, 16'h00FE, 1'b0, 1'b0, 32'h0000_A4A5);
        tick();
        issue(0, 16'h0000, 1'b0, 1'b0, 32'h0000_3C5B);
        tick();
        idle_fetch();
        tick();

        // Reset with a fetch outstanding drops instr_valid at once
        issue(0, 16'h0000, 1'b0, 1'b0, 32'h0000_3C5B);
        tick();
        idle_fetch();
        q16.delete();
        rst_n = 1'b0; #1;
        check("async_valid_clr", 32'(ival), 32'd0);
        check("async_instr_clr", 32'(instr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 5: reset mid-load after three bytes
        set_prog(0, 1'b1, 1'b0, 8'h00);
        tick();
        bq = '{8'hAA, 8'hBB, 8'hCC};
        foreach (bq[i]) begin
            set_prog(0, 1'b1, 1'b1, bq[i]);
            tick();
        end
        set_prog(0, 1'b1, 1'b0, 8'h00);
        check("ptr_before_rst", 32'(pptr), 32'd3);
        rst_n = 1'b0; #1;
        check("async_ptr_clr", 32'(pptr), 32'd0);
        set_prog(0, 1'b0, 1'b0, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("rdy_after_rst", 32'(frdy), 32'd1);
        issue(0, 16'h0000, 1'b0, 1'b0, 32'h0000_AABB);
        tick();
        issue(0, 16'h0002, 1'b0, 1'b0, 32'h0000_CC59);
        tick();
        idle_fetch();
        tick();

        // Test 6: 32-bit / 1024-byte instance
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load_bytes(1, bq);
        check("ptr32_8", 32'(pptr2), 32'd8);
        issue(1, 16'd4, 1'b0, 1'b0, 32'h0506_0708);
        tick();
        issue(1, 16'd0, 1'b0, 1'b0, 32'h0102_0304);
        tick();
        issue(1, 16'd2, 1'b1, 1'b0, 32'h0);
        tick();
        issue(1, 16'd1020, 1'b0, 1'b1, 32'h0);
        tick();
        issue(1, 16'd1021, 1'b1, 1'b0, 32'h0);
        tick();
        issue(1, 16'd1024, 1'b1, 1'b0, 32'h0);
        tick();
        idle_fetch();
        repeat (3) tick();

        check("q16_drained", 32'(q16.size()), 32'd0);
        check("q32_drained", 32'(q32.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
